// File: rtl/multiport_register_file.sv
// Multi-ported register file with per-register pending-write (busy) tracking.
// After reset the array is zeroed one entry per cycle before operations are accepted.
module multiport_register_file #(
  parameter  int XLEN = 32,
  parameter  int NREG = 32,
  parameter  int NRD  = 2,
  parameter  int NWR  = 2,
  localparam int AW   = $clog2(NREG)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NWR-1:0]            we,
  input  logic [NWR-1:0][AW-1:0]    wa,
  input  logic [NWR-1:0][XLEN-1:0]  wd,
  input  logic [NRD-1:0][AW-1:0]    ra,
  output logic [NRD-1:0][XLEN-1:0]  rd,
  output logic [NRD-1:0]            rbusy,
  input  logic                      iss_valid,
  input  logic [AW-1:0]             iss_rd,
  input  logic                      flush,
  output logic                      ready
);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  localparam logic [AW-1:0] ADDR_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0] ADDR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] ADDR_LAST = {AW{1'b1}};

  state_e                    state_q, state_d;
  logic [AW-1:0]             clr_idx_q, clr_idx_d;
  logic [NREG-1:0]           busy_q, busy_d;
  logic [XLEN-1:0]           mem_q [NREG];
  logic [NRD-1:0]            hit_s;
  logic [NRD-1:0][XLEN-1:0]  rdat_s;
  logic                      op_en_s;

  assign op_en_s = (state_q == ST_READY);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_CLEAR;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CLEAR: begin
        if (clr_idx_q == ADDR_LAST) begin
          state_d = ST_READY;
        end else begin
          state_d = ST_CLEAR;
        end
      end
      ST_READY: state_d = ST_READY;
      default:  state_d = ST_CLEAR;
    endcase
  end

  // Output decode of the FSM
  always_comb begin
    ready = 1'b0;
    case (state_q)
      ST_CLEAR: ready = 1'b0;
      ST_READY: ready = 1'b1;
      default:  ready = 1'b0;
    endcase
  end

  // Clear-index next value
  always_comb begin
    clr_idx_d = clr_idx_q;
    if (state_q == ST_CLEAR && clr_idx_q != ADDR_LAST) begin
      clr_idx_d = clr_idx_q + ADDR_ONE;
    end else begin
      clr_idx_d = clr_idx_q;
    end
  end

  // Clear-index register; restarts at 1 because entry 0 is hardwired to zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clr_idx_q <= ADDR_ONE;
    end else begin
      clr_idx_q <= clr_idx_d;
    end
  end

  // Busy next state: write clears, issue sets (wins over write), flush clears all
  always_comb begin
    busy_d = busy_q;
    if (op_en_s) begin
      for (int j = 0; j < NWR; j++) begin
        if (we[j]) begin
          busy_d[wa[j]] = 1'b0;
        end else begin
          busy_d[wa[j]] = busy_d[wa[j]];
        end
      end
      if (iss_valid) begin
        busy_d[iss_rd] = 1'b1;
      end else begin
        busy_d[iss_rd] = busy_d[iss_rd];
      end
      if (flush) begin
        busy_d = {NREG{1'b0}};
      end else begin
        busy_d = busy_d;
      end
    end else begin
      busy_d = busy_q;
    end
    busy_d[0] = 1'b0;
  end

  // Busy bit register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q <= {NREG{1'b0}};
    end else begin
      busy_q <= busy_d;
    end
  end

  // Storage array; later ports overwrite earlier ones so the highest port wins
  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR) begin
      mem_q[clr_idx_q] <= {XLEN{1'b0}};
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (we[j] && wa[j] != ADDR_ZERO) begin
          mem_q[wa[j]] <= wd[j];
        end
      end
    end
  end

  // Read ports with same-cycle write bypass and pending-write flag
  always_comb begin
    hit_s  = {NRD{1'b0}};
    rdat_s = '0;
    rd     = '0;
    rbusy  = {NRD{1'b0}};
    for (int i = 0; i < NRD; i++) begin
      rdat_s[i] = mem_q[ra[i]];
      for (int j = 0; j < NWR; j++) begin
        if (we[j] && wa[j] == ra[i]) begin
          hit_s[i]  = 1'b1;
          rdat_s[i] = wd[j];
        end else begin
          rdat_s[i] = rdat_s[i];
        end
      end
      if (op_en_s && ra[i] != ADDR_ZERO) begin
        rd[i]    = rdat_s[i];
        rbusy[i] = busy_q[ra[i]] & ~hit_s[i];
      end else begin
        rd[i]    = {XLEN{1'b0}};
        rbusy[i] = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_multiport_register_file.sv
// Directed self-checking bench for multiport_register_file (default parameters).
module tb_multiport_register_file;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       we;
  logic [1:0][4:0]  wa;
  logic [1:0][31:0] wd;
  logic [1:0][4:0]  ra;
  logic [1:0][31:0] rd;
  logic [1:0]       rbusy;
  logic             iss_valid;
  logic [4:0]       iss_rd;
  logic             flush;
  logic             ready;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int n_edges;

  multiport_register_file dut (
    .clk       (clk),
    .reset     (reset),
    .we        (we),
    .wa        (wa),
    .wd        (wd),
    .ra        (ra),
    .rd        (rd),
    .rbusy     (rbusy),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .flush     (flush),
    .ready     (ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    we        = 2'b00;
    wa        = '0;
    wd        = '0;
    iss_valid = 1'b0;
    iss_rd    = 5'd0;
    flush     = 1'b0;
  endtask

  // Counts rising edges until ready, starting from an already-elapsed count.
  task automatic wait_ready(input int start, output int n);
    n = start;
    while (ready !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    reset = 1'b0;
    idle();
    ra = '0;
    #1;
    check("reset_ready", {31'd0, ready}, 32'd0);
    ra[0] = 5'd3;
    #1;
    check("reset_rd0", rd[0], 32'd0);
    check("reset_rbusy", {30'd0, rbusy}, 32'd0);

    repeat (3) @(negedge clk);
    reset = 1'b1;
    wait_ready(0, n_edges);
    check("ready_after_31", n_edges, 32'd31);

    for (int a = 0; a < 32; a++) begin
      ra[0] = 5'(a);
      ra[1] = 5'(31 - a);
      #1;
      check("init_zero_p0", rd[0], 32'd0);
      check("init_zero_p1", rd[1], 32'd0);
    end

    // Same-address dual write: port 1 wins, bypassed and stored
    @(negedge clk);
    we = 2'b11; wa[0] = 5'd5; wa[1] = 5'd5;
    wd[0] = 32'hAAAA0000; wd[1] = 32'h12345678; ra[0] = 5'd5;
    #1;
    check("bypass_hi_port", rd[0], 32'h12345678);
    @(negedge clk);
    idle();
    #1;
    check("stored_hi_port", rd[0], 32'h12345678);

    // Single-port write on port 0 to another address
    @(negedge clk);
    we = 2'b01; wa[0] = 5'd6; wd[0] = 32'h0BADF00D; ra[1] = 5'd6;
    #1;
    check("bypass_p0", rd[1], 32'h0BADF00D);
    @(negedge clk);
    idle();
    #1;
    check("stored_p0", rd[1], 32'h0BADF00D);
    check("other_reg_kept", rd[0], 32'h12345678);

    // Writes to register 0 are discarded
    @(negedge clk);
    we = 2'b01; wa[0] = 5'd0; wd[0] = 32'hFFFFFFFF; ra[1] = 5'd0;
    #1;
    check("r0_bypass", rd[1], 32'd0);
    @(negedge clk);
    idle();
    #1;
    check("r0_stored", rd[1], 32'd0);

    // Issue sets busy; a write clears it in the same cycle and after
    @(negedge clk);
    iss_valid = 1'b1; iss_rd = 5'd7; ra[0] = 5'd7;
    #1;
    check("busy7_before", {31'd0, rbusy[0]}, 32'd0);
    @(negedge clk);
    idle();
    #1;
    check("busy7_set", {31'd0, rbusy[0]}, 32'd1);
    @(negedge clk);
    we = 2'b10; wa[1] = 5'd7; wd[1] = 32'h00000077;
    #1;
    check("busy7_wr_hide", {31'd0, rbusy[0]}, 32'd0);
    check("rd7_bypass", rd[0], 32'h00000077);
    @(negedge clk);
    idle();
    #1;
    check("busy7_cleared", {31'd0, rbusy[0]}, 32'd0);

    // Issue and write to the same register: set wins, data lands
    @(negedge clk);
    iss_valid = 1'b1; iss_rd = 5'd9;
    we = 2'b01; wa[0] = 5'd9; wd[0] = 32'h00000099;
    @(negedge clk);
    idle();
    ra[0] = 5'd9;
    #1;
    check("busy9_set_wins", {31'd0, rbusy[0]}, 32'd1);
    check("rd9_written", rd[0], 32'h00000099);

    // Flush overrides issue, same-cycle write still commits
    @(negedge clk);
    flush = 1'b1; iss_valid = 1'b1; iss_rd = 5'd3;
    we = 2'b01; wa[0] = 5'd12; wd[0] = 32'h0000000C;
    @(negedge clk);
    idle();
    ra[0] = 5'd3; ra[1] = 5'd9;
    #1;
    check("flush_busy3", {31'd0, rbusy[0]}, 32'd0);
    check("flush_busy9", {31'd0, rbusy[1]}, 32'd0);
    ra[0] = 5'd12;
    #1;
    check("flush_wr_commit", rd[0], 32'h0000000C);

    // Leave register 20 pending, then reset mid-clear
    @(negedge clk);
    iss_valid = 1'b1; iss_rd = 5'd20;
    @(negedge clk);
    idle();
    reset = 1'b0;
    #1;
    check("rst_ready_low", {31'd0, ready}, 32'd0);
    check("rst_rd_zero", rd[0], 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midclear_ready", {31'd0, ready}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    we = 2'b01; wa[0] = 5'd3; wd[0] = 32'h0000DEAD; ra[0] = 5'd3;
    iss_valid = 1'b1; iss_rd = 5'd4; flush = 1'b0;
    #1;
    check("clear_rd_zero", rd[0], 32'd0);
    check("clear_ready_low", {31'd0, ready}, 32'd0);
    @(negedge clk);
    idle();
    wait_ready(21, n_edges);
    check("ready_after_restart", n_edges, 32'd31);

    ra[0] = 5'd3; ra[1] = 5'd12;
    #1;
    check("clear_we_ignored", rd[0], 32'd0);
    check("reg12_recleared", rd[1], 32'd0);
    ra[0] = 5'd20; ra[1] = 5'd4;
    #1;
    check("busy20_discarded", {31'd0, rbusy[0]}, 32'd0);
    check("clear_iss_ignored", {31'd0, rbusy[1]}, 32'd0);
    ra[0] = 5'd5;
    #1;
    check("reg5_recleared", rd[0], 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
